// File: rtl/alu_issue.sv
// Request queue in front of an external combinational ALU, with a registered
// result stage. Requests issue in FIFO order; the ALU result is captured unmodified.
module alu_issue #(
    parameter int WIDTH = 32,
    parameter int OPW   = 4,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         in_a,
    input  logic [WIDTH-1:0]         in_b,
    input  logic [OPW-1:0]           in_op,
    output logic [WIDTH-1:0]         alu_a,
    output logic [WIDTH-1:0]         alu_b,
    output logic [OPW-1:0]           alu_op,
    input  logic [WIDTH-1:0]         alu_r,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         out_r,
    output logic [OPW-1:0]           out_op,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic {IDLE, HOLD} state_t;

    state_t             state;
    logic [WIDTH-1:0]   mem_a  [DEPTH];
    logic [WIDTH-1:0]   mem_b  [DEPTH];
    logic [OPW-1:0]     mem_op [DEPTH];
    logic [PW-1:0]      wr_ptr;
    logic [PW-1:0]      rd_ptr;
    logic               empty;
    logic               push;
    logic               issue;

    // A full queue stays not-ready even if a pop happens in the same cycle.
    assign empty    = (count == '0);
    assign in_ready = (count < CW'(DEPTH));
    assign push     = in_valid && in_ready;
    assign issue    = !empty && (state == IDLE || out_ready);

    // NOTE: every output gets a default first so no path leaves one unassigned (no latch).
    always_comb begin
        alu_a  = '0;
        alu_b  = '0;
        alu_op = '0;
        if (!empty) begin
            alu_a  = mem_a[rd_ptr];
            alu_b  = mem_b[rd_ptr];
            alu_op = mem_op[rd_ptr];
        end
    end

    // NOTE: storage is deliberately not reset; occupancy and pointers alone define validity.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_a[wr_ptr]  <= in_a;
            mem_b[wr_ptr]  <= in_b;
            mem_op[wr_ptr] <= in_op;
        end
    end

    // NOTE: state is updated with non-blocking assignments so every read sees the pre-edge value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            out_r     <= '0;
            out_op    <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (issue)
                rd_ptr <= rd_ptr + 1'b1;

            case ({push, issue})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase

            case (state)
                IDLE: begin
                    if (issue) begin
                        out_r     <= alu_r;
                        out_op    <= alu_op;
                        out_valid <= 1'b1;
                        state     <= HOLD;
                    end
                end
                HOLD: begin
                    if (issue) begin
                        out_r  <= alu_r;
                        out_op <= alu_op;
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_issue.sv
// Randomized scoreboard bench for alu_issue: expected results are queued at
// acceptance and compared in order whenever a result is handed off.
module tb_alu_issue;

    localparam int W  = 32;
    localparam int OW = 4;
    localparam int D  = 4;

    typedef struct {
        logic [W-1:0]  r;
        logic [OW-1:0] op;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [W-1:0]      in_a;
    logic [W-1:0]      in_b;
    logic [OW-1:0]     in_op;
    logic [W-1:0]      alu_a;
    logic [W-1:0]      alu_b;
    logic [OW-1:0]     alu_op;
    logic [W-1:0]      alu_r;
    logic              out_valid;
    logic              out_ready;
    logic [W-1:0]      out_r;
    logic [OW-1:0]     out_op;
    logic [$clog2(D):0] count;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   n_out    = 0;
    exp_t exp_q[$];
    exp_t mon_e;

    alu_issue #(.WIDTH(W), .OPW(OW), .DEPTH(D)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_op     (in_op),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_op    (alu_op),
        .alu_r     (alu_r),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_r     (out_r),
        .out_op    (out_op),
        .count     (count)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] ref_alu(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input logic [OW-1:0] op);
        case (op)
            4'd0:    return a + b;
            4'd1:    return a - b;
            4'd2:    return a & b;
            4'd3:    return a | b;
            4'd4:    return a ^ b;
            4'd5:    return a << b[4:0];
            default: return a;
        endcase
    endfunction

    // External ALU stub.
    assign alu_r = ref_alu(alu_a, alu_b, alu_op);

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected result is derived from the request itself when it is accepted.
    always @(negedge clk) begin
        if (!rst && in_valid && in_ready)
            exp_q.push_back('{r: ref_alu(in_a, in_b, in_op), op: in_op});
    end

    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            n_out++;
            if (exp_q.size() == 0) begin
                check("unexpected_result", 1, 0);
            end else begin
                mon_e = exp_q.pop_front();
                check("out_r", out_r, mon_e.r);
                check("out_op", out_op, mon_e.op);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic [OW-1:0] op);
        bit accepted = 0;
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        in_op    = op;
        for (int i = 0; i < 200 && !accepted; i++) begin
            @(negedge clk);
            if (in_ready) begin
                tick();
                accepted = 1;
            end
        end
        if (!accepted)
            check("send_timeout", 0, 1);
    endtask

    task automatic drain();
        bit done = 0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 100 && !done; i++) begin
            tick();
            if (exp_q.size() == 0 && !out_valid)
                done = 1;
        end
        check("drain_done", done, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] held;
        int           n0;

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        in_a = '0; in_b = '0; in_op = '0;
        repeat (2) tick();

        // Values while reset is held.
        check("rst_count", count, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_r", out_r, 0);
        check("rst_out_op", out_op, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_alu", {alu_a, alu_b, 28'd0, alu_op}, 0);

        // Single request right after reset release: accepted at the first edge.
        rst = 1'b0;
        send(32'd5, 32'd3, 4'd0);
        in_valid = 1'b0;
        check("lat_count1", count, 1);
        check("lat_valid_early", out_valid, 0);
        check("lat_head_a", alu_a, 5);
        tick();
        check("lat_valid", out_valid, 1);
        check("lat_out_r", out_r, 8);
        check("lat_out_op", out_op, 0);
        check("lat_count0", count, 0);
        tick();
        check("lat_idle", out_valid, 0);

        // Empty queue: zero ALU drive and no issue.
        for (int i = 0; i < 3; i++) begin
            check("empty_alu", {alu_a, alu_b, 28'd0, alu_op}, 0);
            check("empty_no_issue", out_valid, 0);
            tick();
        end

        // Backpressure fill: one held result plus a full queue.
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++)
            send($urandom, $urandom, 4'($urandom_range(0, 6)));
        check("fill_count", count, 4);
        check("fill_in_ready", in_ready, 0);
        check("fill_valid", out_valid, 1);
        check("fill_held_r", out_r, exp_q[0].r);
        held = out_r;
        in_a = $urandom;
        repeat (3) tick();
        check("fill_count_stuck", count, 4);
        check("fill_out_r_stable", out_r, held);
        drain();

        // Streaming: one result per cycle, queue never builds up.
        out_ready = 1'b1;
        n0 = n_out;
        for (int i = 0; i < 16; i++) begin
            send($urandom, $urandom, 4'($urandom_range(0, 6)));
            if (i > 0)
                check("stream_valid", out_valid, 1);
            check("stream_count_le1", count <= 1, 1);
        end
        in_valid = 1'b0;
        tick();
        check("stream_last_valid", out_valid, 1);
        check("stream_last_count", count, 0);
        drain();
        check("stream_n_results", n_out - n0, 16);

        // Wrap-around with alternating consumer readiness.
        n0 = n_out;
        for (int i = 0; i < 10; i++) begin
            out_ready = i[0];
            send($urandom, $urandom, 4'($urandom_range(0, 6)));
        end
        drain();
        check("wrap_n_results", n_out - n0, 10);

        // Random traffic on both sides.
        for (int i = 0; i < 300; i++) begin
            in_valid  = 1'($urandom_range(0, 1));
            in_a      = $urandom;
            in_b      = $urandom;
            in_op     = 4'($urandom_range(0, 6));
            out_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        drain();

        // Reset mid-stream acts without a clock edge.
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++)
            send($urandom, $urandom, 4'($urandom_range(0, 6)));
        in_valid = 1'b0;
        check("pre_rst_count", count, 3);
        check("pre_rst_valid", out_valid, 1);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_count", count, 0);
        check("mid_rst_in_ready", in_ready, 1);
        check("mid_rst_alu_a", alu_a, 0);
        exp_q.delete();
        tick();
        rst = 1'b0;
        out_ready = 1'b1;
        n0 = n_out;
        send(32'd100, 32'd58, 4'd1);
        in_valid = 1'b0;
        tick();
        check("post_rst_out_r", out_r, 42);
        drain();
        check("post_rst_n_results", n_out - n0, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_issue.md
ALU_ISSUE -- requirements
Module: alu_issue

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/result width (matches data_t).
REQ-002 SHALL have parameter OPW, default 4, opcode width (encoding of type_op).
REQ-003 SHALL have parameter DEPTH, default 4, request queue entries; power of two, at least 2.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port in_valid  input  1  request offered.
REQ-007 SHALL have port in_ready  output  1  queue can accept a request.
REQ-008 SHALL have ports in_a, in_b  input  WIDTH  request operands.
REQ-009 SHALL have port in_op  input  OPW  request opcode.
REQ-010 SHALL have ports alu_a, alu_b  output  WIDTH  operands driven to the combinational ALU.
REQ-011 SHALL have port alu_op  output  OPW  opcode driven to the ALU.
REQ-012 SHALL have port alu_r  input  WIDTH  ALU result, combinational function of alu_a/alu_b/alu_op.
REQ-013 SHALL have port out_valid  output  1  result register holds a valid result.
REQ-014 SHALL have port out_ready  input  1  consumer accepts the result.
REQ-015 SHALL have ports out_r  output  WIDTH and out_op  output  OPW  captured result and its opcode.
REQ-016 SHALL have port count  output  $clog2(DEPTH)+1  current queue occupancy.

Function
REQ-017 Push: in_valid && in_ready at an edge SHALL write {in_a, in_b, in_op} at the write pointer and advance it modulo DEPTH.
REQ-018 in_ready SHALL equal (count < DEPTH); a pop in the same cycle SHALL NOT raise in_ready (no full-queue bypass).
REQ-019 alu_a/alu_b/alu_op SHALL be driven directly from the head entry; when count == 0 they SHALL be all zeros.
REQ-020 Output register states: IDLE (out_valid=0), HOLD (out_valid=1).
REQ-021 Issue condition: count > 0 && (!out_valid || out_ready).
REQ-022 On issue SHALL capture alu_r into out_r and alu_op into out_op, set out_valid=1, and pop the head (read pointer +1 modulo DEPTH).
REQ-023 HOLD with out_ready=1 and count==0 SHALL return to IDLE; HOLD with out_ready=0 SHALL keep out_r/out_op stable.
REQ-024 Simultaneous push and issue SHALL leave count unchanged; push-only SHALL increment count, issue-only SHALL decrement it.
REQ-025 Minimum latency: a request accepted at edge k into an empty queue with IDLE output SHALL appear with out_valid=1 after edge k+1.
REQ-026 Sustained throughput with out_ready=1 and a continuous input stream SHALL be one result per cycle.
REQ-027 Pointers SHALL wrap from DEPTH-1 to 0 without loss or duplication; order SHALL be strictly FIFO.
REQ-028 No arithmetic SHALL be performed inside the block; out_r SHALL equal alu_r bit-exactly as sampled at the issue edge.

Reset
REQ-029 While rst is high: count=0, both pointers=0, out_valid=0, out_r=0, out_op=0, in_ready=1, alu_a/alu_b/alu_op=0.
REQ-030 Assertion mid-operation SHALL immediately discard all queued requests and any held result; queue storage contents need not be cleared.
REQ-031 The first push SHALL be accepted at the first rising edge after rst deasserts.

Verification
REQ-032 Single request: a=5, b=3, op=ADD, out_ready=1 -> out_valid high one cycle after acceptance, out_r=8, out_op=ADD, count back to 0.
REQ-033 Backpressure fill: out_ready=0, push 5 requests (DEPTH=4) -> 1 held in output, 4 queued, count=4, in_ready=0, out_r stable; then out_ready=1 -> all 5 results drain in push order.
REQ-034 Streaming: 16 back-to-back requests, out_ready=1 -> 16 consecutive out_valid cycles, results in order, count never exceeds 1.
REQ-035 Wrap-around: 10 push/pop cycles with alternating out_ready -> pointers wrap twice, no lost or duplicated results.
REQ-036 Reset mid-stream: rst pulses with count=3 and out_valid=1 -> out_valid=0 and count=0 immediately (no clock edge needed), in_ready=1; the next request yields the correct result.
REQ-037 Empty queue: count=0 -> alu_a=alu_b=alu_op=0 and no issue occurs while in_valid=0.
